// File: rtl/pipeline_program_loader.sv
// UART-driven program loader and run/step controller in front of the 5-stage MIPS pipeline.
// Single-byte commands load big-endian words into instruction memory, run until halt, or single step.
module pipeline_program_loader #(
  parameter int         ADDR_WIDTH = 10,
  parameter logic [7:0] CMD_LOAD   = 8'h4C,
  parameter logic [7:0] CMD_RUN    = 8'h52,
  parameter logic [7:0] CMD_STEP   = 8'h53
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  halt,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  pipe_enable,
  output logic                  pipe_reset,
  output logic                  load_done,
  output logic                  busy
);
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, FINISH, RUN} stateT;

  stateT                 state, stateNext;
  logic [15:0]           wordCount, wordCountNext;
  logic [1:0]            byteIdx, byteIdxNext;
  logic [31:0]           shiftReg, shiftRegNext;
  logic [ADDR_WIDTH-1:0] addrNext;
  logic [31:0]           wdataNext;
  logic                  weNext;
  logic                  stepNext;
  logic [15:0]           lenFull;
  logic [31:0]           wordFull;

  assign lenFull  = {wordCount[15:8], rx_data};
  assign wordFull = {shiftReg[23:0], rx_data};

  always_comb begin
    stateNext     = state;
    wordCountNext = wordCount;
    byteIdxNext   = byteIdx;
    shiftRegNext  = shiftReg;
    addrNext      = imem_addr;
    wdataNext     = imem_wdata;
    weNext        = 1'b0;
    stepNext      = 1'b0;
    case (state)
      IDLE: begin
        addrNext = '0;
        if (rx_valid) begin
          if (rx_data == CMD_LOAD)      stateNext = LEN_HI;
          else if (rx_data == CMD_RUN)  stateNext = RUN;
          else if (rx_data == CMD_STEP) stepNext  = 1'b1;
        end
      end
      LEN_HI: begin
        if (rx_valid) begin
          wordCountNext = {rx_data, 8'h00};
          stateNext     = LEN_LO;
        end
      end
      LEN_LO: begin
        if (rx_valid) begin
          wordCountNext = lenFull;
          byteIdxNext   = '0;
          shiftRegNext  = '0;
          addrNext      = '0;
          stateNext     = (lenFull == 16'd0) ? FINISH : DATA;
        end
      end
      DATA: begin
        // The address advances in the write cycle itself, so a byte landing there is still accepted.
        if (imem_we) addrNext = imem_addr + 1'b1;
        if (imem_we && wordCount == 16'd0) begin
          stateNext = FINISH;
        end else if (rx_valid && wordCount != 16'd0) begin
          shiftRegNext = wordFull;
          byteIdxNext  = byteIdx + 2'd1;
          if (byteIdx == 2'd3) begin
            weNext        = 1'b1;
            wdataNext     = wordFull;
            wordCountNext = wordCount - 16'd1;
          end
        end
      end
      FINISH: begin
        stateNext = IDLE;
        addrNext  = '0;
      end
      RUN: begin
        if (halt && pipe_enable) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Outputs are registered against the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wordCount   <= '0;
      byteIdx     <= '0;
      shiftReg    <= '0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      pipe_enable <= 1'b0;
      pipe_reset  <= 1'b0;
      load_done   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= stateNext;
      wordCount   <= wordCountNext;
      byteIdx     <= byteIdxNext;
      shiftReg    <= shiftRegNext;
      imem_we     <= weNext;
      imem_addr   <= addrNext;
      imem_wdata  <= wdataNext;
      pipe_enable <= (stateNext == RUN) || stepNext;
      pipe_reset  <= (stateNext == FINISH);
      load_done   <= (stateNext == FINISH);
      busy        <= (stateNext != IDLE);
    end
  end
endmodule

// File: tb/tb_pipeline_program_loader.sv
// Randomized bench for pipeline_program_loader: two instances (10-bit and 2-bit addresses) share
// one byte stream; observed events are compared with expectations derived from the command rules.
module tb_pipeline_program_loader;
  localparam logic [7:0] L = 8'h4C, R = 8'h52, S = 8'h53;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic        halt = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        we0, pe0, pr0, ld0, bz0;
  logic [9:0]  addr0;
  logic [31:0] wd0;
  logic        we1, pe1, pr1, ld1, bz1;
  logic [1:0]  addr1;
  logic [31:0] wd1;
  int          cyc = 0;
  int          nCompared = 0, nMismatched = 0;

  typedef struct {int cyc; int addr; logic [31:0] data;} wr_t;
  wr_t         wrQ[2][$];
  int          enQ[2][$];
  int          doneCnt[2], doneCyc[2], rstCnt[2], rstCyc[2], busyCnt[2];
  logic [31:0] memAct[2][1024];
  logic [31:0] memExp[2][1024];
  bit          memSet[2][1024];
  logic [31:0] tbWords[$];
  int          wrB[2], enB[2], doneB[2], rstB[2], busyB[2];

  pipeline_program_loader dut0 (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .halt(halt),
    .imem_we(we0), .imem_addr(addr0), .imem_wdata(wd0), .pipe_enable(pe0),
    .pipe_reset(pr0), .load_done(ld0), .busy(bz0)
  );

  pipeline_program_loader #(.ADDR_WIDTH(2)) dut1 (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .halt(halt),
    .imem_we(we1), .imem_addr(addr1), .imem_wdata(wd1), .pipe_enable(pe1),
    .pipe_reset(pr1), .load_done(ld1), .busy(bz1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic record(input int i, input logic we, input int addr, input logic [31:0] wd,
                        input logic pe, input logic pr, input logic ld, input logic bz);
    if (we) begin
      wrQ[i].push_back('{cyc, addr, wd});
      memAct[i][addr] = wd;
    end
    if (pe) enQ[i].push_back(cyc);
    if (ld) begin doneCnt[i]++; doneCyc[i] = cyc; end
    if (pr) begin rstCnt[i]++; rstCyc[i] = cyc; end
    if (bz) busyCnt[i]++;
  endtask

  // Event monitor: outputs sampled on the falling edge, tagged with the rising-edge count.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      record(0, we0, int'(addr0), wd0, pe0, pr0, ld0, bz0);
      record(1, we1, int'(addr1), wd1, pe1, pr1, ld1, bz1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic snap();
    for (int i = 0; i < 2; i++) begin
      wrB[i] = wrQ[i].size(); enB[i] = enQ[i].size();
      doneB[i] = doneCnt[i]; rstB[i] = rstCnt[i]; busyB[i] = busyCnt[i];
    end
  endtask

  // Byte is sampled at the next rising edge; edgeNo is that edge's count.
  task automatic sendByte(input logic [7:0] b, input int gap, output int edgeNo);
    rx_data = b; rx_valid = 1'b1; edgeNo = cyc + 1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  function automatic logic [7:0] unknownByte();
    logic [7:0] b;
    do b = 8'($urandom); while (b == L || b == R || b == S);
    return b;
  endfunction

  task automatic checkQuiet(input int i, input string what);
    chk($sformatf("%s_writes[%0d]", what, i), wrQ[i].size() - wrB[i], 0);
    chk($sformatf("%s_done[%0d]", what, i), doneCnt[i] - doneB[i], 0);
  endtask

  task automatic doLoad(input int n, input int maxGap);
    int lEdge, e, doneExp, depth;
    int wEdge[$];
    logic [31:0] ws[$];
    logic [31:0] w;
    logic [15:0] n16;
    n16 = n[15:0];
    snap();
    sendByte(L, $urandom_range(maxGap, 0), lEdge);
    sendByte(n16[15:8], $urandom_range(maxGap, 0), e);
    sendByte(n16[7:0], $urandom_range(maxGap, 0), e);
    doneExp = e;
    for (int k = 0; k < n; k++) begin
      w = (k < tbWords.size()) ? tbWords[k] : $urandom;
      for (int b = 0; b < 4; b++) sendByte(w[31-8*b -: 8], $urandom_range(maxGap, 0), e);
      wEdge.push_back(e);
      ws.push_back(w);
    end
    if (n > 0) doneExp = wEdge[n-1] + 1;
    tbWords.delete();
    repeat (4) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      depth = (i == 0) ? 1024 : 4;
      chk($sformatf("wr_count[%0d]", i), wrQ[i].size() - wrB[i], n);
      for (int k = 0; k < n && wrB[i] + k < wrQ[i].size(); k++) begin
        chk($sformatf("wr_addr[%0d][%0d]", i, k), wrQ[i][wrB[i]+k].addr, k % depth);
        chk($sformatf("wr_data[%0d][%0d]", i, k), wrQ[i][wrB[i]+k].data, ws[k]);
        chk($sformatf("wr_cycle[%0d][%0d]", i, k), wrQ[i][wrB[i]+k].cyc, wEdge[k]);
      end
      for (int k = 0; k < n; k++) begin
        memExp[i][k % depth] = ws[k];
        memSet[i][k % depth] = 1'b1;
      end
      chk($sformatf("done_count[%0d]", i), doneCnt[i] - doneB[i], 1);
      chk($sformatf("done_cycle[%0d]", i), doneCyc[i], doneExp);
      chk($sformatf("preset_count[%0d]", i), rstCnt[i] - rstB[i], 1);
      chk($sformatf("preset_cycle[%0d]", i), rstCyc[i], doneExp);
      chk($sformatf("busy_cycles[%0d]", i), busyCnt[i] - busyB[i], doneExp - lEdge + 1);
      chk($sformatf("load_enable[%0d]", i), enQ[i].size() - enB[i], 0);
    end
    chk("addr_idle0", addr0, 0);
    chk("addr_idle1", addr1, 0);
    $display("load  n=%0d words, finish at edge %0d", n, doneExp);
  endtask

  task automatic doRun(input int runLen, input bit midStep);
    int rEdge, hEdge, e;
    snap();
    sendByte(R, runLen, rEdge);
    if (midStep) sendByte(S, 2, e);
    halt = 1'b1; hEdge = cyc + 1;
    @(negedge clk);
    halt = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("run_enable_cycles[%0d]", i), enQ[i].size() - enB[i], hEdge - rEdge);
      if (enQ[i].size() > enB[i]) begin
        chk($sformatf("run_first[%0d]", i), enQ[i][enB[i]], rEdge);
        chk($sformatf("run_last[%0d]", i), enQ[i][enQ[i].size()-1], hEdge - 1);
      end
      chk($sformatf("run_busy[%0d]", i), busyCnt[i] - busyB[i], hEdge - rEdge);
      checkQuiet(i, "run");
    end
    $display("run   from edge %0d halt at edge %0d midStep=%0d", rEdge, hEdge, midStep);
  endtask

  task automatic doStep(input int nS);
    int e;
    int expEn[$];
    snap();
    for (int k = 0; k < nS; k++) begin
      if ($urandom_range(1, 0) == 1) sendByte(unknownByte(), $urandom_range(2, 0), e);
      sendByte(S, $urandom_range(5, 0), e);
      expEn.push_back(e);
    end
    sendByte(8'h00, 3, e);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("step_count[%0d]", i), enQ[i].size() - enB[i], nS);
      for (int k = 0; k < nS && enB[i] + k < enQ[i].size(); k++)
        chk($sformatf("step_cycle[%0d][%0d]", i, k), enQ[i][enB[i]+k], expEn[k]);
      chk($sformatf("step_busy[%0d]", i), busyCnt[i] - busyB[i], 0);
      checkQuiet(i, "step");
    end
    $display("step  %0d pulses", nS);
  endtask

  task automatic doHaltIdle();
    snap();
    halt = 1'b1;
    repeat (5) @(negedge clk);
    halt = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("idle_halt_enable[%0d]", i), enQ[i].size() - enB[i], 0);
      chk($sformatf("idle_halt_busy[%0d]", i), busyCnt[i] - busyB[i], 0);
    end
    $display("halt  while idle");
  endtask

  task automatic doResetMidData();
    int e;
    sendByte(L, 0, e);
    sendByte(8'h00, 0, e);
    sendByte(8'h02, 0, e);
    for (int k = 0; k < 6; k++) sendByte(8'($urandom), 0, e);
    // The aborted load has already written its first word to address 0 in both instances.
    #2 reset = 1'b1;
    #1;
    chk("reset_mid_outputs0", {we0, addr0, wd0, pe0, pr0, ld0, bz0}, 0);
    chk("reset_mid_outputs1", {we1, addr1, wd1, pe1, pr1, ld1, bz1}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    $display("reset asserted mid-load");
    tbWords.push_back(32'hAABBCCDD);
    doLoad(1, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs0", {we0, addr0, wd0, pe0, pr0, ld0, bz0}, 0);
    chk("reset_outputs1", {we1, addr1, wd1, pe1, pr1, ld1, bz1}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    $display("reset released");

    tbWords.push_back(32'h20080005);
    tbWords.push_back(32'h0000000C);
    doLoad(2, 0);
    doLoad(0, 1);
    doHaltIdle();
    doRun(20, 1'b1);
    doStep(3);
    for (int k = 1; k <= 5; k++) tbWords.push_back(32'(k));
    doLoad(5, 1);
    chk("wrap_addr0", memAct[1][0], 32'd5);
    chk("nowrap_addr0", memAct[0][0], 32'd1);
    doResetMidData();

    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(2, 0))
        0:       doLoad($urandom_range(6, 0), 2);
        1:       doRun($urandom_range(15, 1), 1'($urandom_range(1, 0)));
        default: doStep($urandom_range(4, 1));
      endcase
    end

    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 1024; a++)
        if (memSet[i][a]) chk($sformatf("mem[%0d][%0d]", i, a), memAct[i][a], memExp[i][a]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule

// File: doc/pipeline_program_loader.md
Name: pipeline_program_loader

Overview:
- Sits directly upstream of the 5-stage MIPS pipeline.
- Consumes a byte stream from the UART receiver and decodes single-byte commands.
- On a load command, assembles big-endian 32-bit words and writes them into instruction memory from word address 0.
- Gates pipeline execution through pipe_enable (continuous run or single step) and pulses pipe_reset after each program load.

Parameters:
- ADDR_WIDTH, 10, instruction-memory word-address width; depth = 2^ADDR_WIDTH words.
- CMD_LOAD, 8'h4C, command byte 'L' that starts a program load.
- CMD_RUN, 8'h52, command byte 'R' that runs until halt.
- CMD_STEP, 8'h53, command byte 'S' that advances the pipeline one cycle.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx_data  input  8  received UART byte; valid only when rx_valid=1.
- rx_valid  input  1  one-cycle strobe per received byte.
- halt  input  1  pipeline reports a halt instruction; sampled only while pipe_enable=1.
- imem_we  output  1  instruction-memory write enable, one cycle per word.
- imem_addr  output  ADDR_WIDTH  instruction-memory word address.
- imem_wdata  output  32  instruction word to write.
- pipe_enable  output  1  clock enable for all pipeline registers and the PC.
- pipe_reset  output  1  one-cycle synchronous clear request to the pipeline.
- load_done  output  1  one-cycle pulse when a load completes.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; all outputs 0.
  - imem_addr=0; word count, byte index and shift register cleared.
  - Memory contents already written are not restored.
- States: IDLE, LEN_HI, LEN_LO, DATA, FINISH, RUN. All outputs are registered.
- IDLE, on rx_valid:
  - CMD_LOAD -> LEN_HI.
  - CMD_RUN -> RUN; pipe_enable=1 from the next cycle.
  - CMD_STEP -> pipe_enable=1 for exactly the next cycle; stays IDLE; busy stays 0.
  - Any other byte is ignored.
- LEN_HI / LEN_LO:
  - Capture word count N (16-bit, high byte first).
  - If N=0 after LEN_LO -> FINISH; otherwise -> DATA with byte index 0 and imem_addr=0.
- DATA:
  - Each rx_valid shifts rx_data into the low byte of a 32-bit shift register; the first byte received ends up as bits [31:24].
  - On the 4th byte of a word: the next cycle drives imem_we=1, imem_wdata=word, imem_addr=current address, for one cycle.
  - The address increments in the cycle after the write.
  - Byte index resets and the remaining count decrements.
  - After the write of the last word -> FINISH.
- Address wrap: imem_addr wraps modulo 2^ADDR_WIDTH. If N exceeds the depth, later words overwrite earlier ones; there is no error.
- FINISH:
  - Lasts one cycle; pipe_reset=1 and load_done=1 together in that cycle; then -> IDLE.
  - imem_addr returns to 0 on entry to IDLE.
- RUN:
  - pipe_enable held at 1.
  - halt=1 sampled at an edge -> pipe_enable=0 from the next cycle; -> IDLE.
  - rx bytes received in RUN are ignored.
- pipe_enable is 0 in LEN_HI, LEN_LO, DATA and FINISH.
- Bytes arriving while imem_we=1 are accepted; back-to-back rx_valid on consecutive cycles must never drop a byte.
- A halt input outside RUN/STEP has no effect.
- Latency: rx_valid of the 4th byte at edge k -> imem_we high during cycle k+1.

Test Plan:
- Reset mid-DATA (after 6 of 8 bytes): all outputs 0 immediately, state IDLE. A following 'L',00,01,AA,BB,CC,DD writes 32'hAABBCCDD to addr 0.
- Load two words: 4C,00,02,20,08,00,05,00,00,00,0C -> imem_we pulses twice, addr0=32'h20080005 then addr1=32'h0000000C. Next, one cycle with pipe_reset=load_done=1, busy=1 throughout, then busy=0.
- Zero-length load: 4C,00,00 -> no imem_we; FINISH pulse the cycle after the length byte; back to IDLE.
- Run/halt: 'R' -> pipe_enable=1 starting the next cycle. halt asserted 20 cycles later -> pipe_enable=0 one cycle after. A byte 'S' sent mid-run is ignored.
- Step: three 'S' bytes spaced 5 cycles apart -> exactly three single-cycle pipe_enable pulses, each one cycle after its rx_valid. Unknown byte 8'h00 -> no output change.
- Wrap, with ADDR_WIDTH=2: load N=5 words with values 1..5 -> writes at addrs 0,1,2,3,0; addr0 final value 5; load_done asserted once.
